fir_filter_tdm: RTL and testbench

Time-division-multiplexed FIR filter: CH independent channels, order N (N+1 taps), one shared signed multiply-accumulator stepped once per tap. It is the parametrised successor of the single-channel fully parallel FIR filter. It adds valid/ready streaming on input and output, run-time coefficient writes, per-channel sample history and a synchronous history clear. It sits between a channel-tagged sample source and a downstream consumer that can stall.

---
 rtl/fir_filter_tdm_pkg.sv | 14 +
 rtl/fir_filter_tdm_mac.sv | 36 +++
 rtl/fir_filter_tdm.sv | 140 ++++++++++++++
 tb/tb_fir_filter_tdm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_filter_tdm_pkg.sv
// Shared definitions for the time-division-multiplexed FIR filter:
// FSM state encodings and the output-width helper.
package fir_tdm_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    // Output width that holds every exact sum of (n+1) products of wx-by-wb bit signed values
    function automatic int calc_width_y(input int wx, input int wb, input int n);
        return wx + wb + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fir_filter_tdm_mac.sv
// Registered signed multiply-accumulator shared by all taps and channels.
// sum exposes acc + x*b so the caller can capture the final total on the last step.
module fir_mac #(
    parameter int WIDTH_X = 4,
    parameter int WIDTH_B = 4,
    parameter int WIDTH_Y = 10
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic signed [WIDTH_X-1:0] x,
    input  logic signed [WIDTH_B-1:0] b,
    output logic signed [WIDTH_Y-1:0] sum
);

    logic signed [WIDTH_Y-1:0] acc;
    logic signed [WIDTH_Y-1:0] x_ext;
    logic signed [WIDTH_Y-1:0] b_ext;
    logic signed [WIDTH_Y-1:0] prod;

    // Operands are widened to the accumulator width first so the product is exact
    assign x_ext = {{(WIDTH_Y - WIDTH_X){x[WIDTH_X-1]}}, x};
    assign b_ext = {{(WIDTH_Y - WIDTH_B){b[WIDTH_B-1]}}, b};
    assign prod  = x_ext * b_ext;
    assign sum   = acc + prod;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/fir_filter_tdm.sv
// Multi-channel FIR filter that steps one shared MAC through the taps of a
// channel-tagged sample, with valid/ready on both sides and runtime coefficients.
module fir_filter_tdm
    import fir_tdm_pkg::*;
#(
    parameter int N       = 3,
    parameter int CH      = 2,
    parameter int WIDTH_X = 4,
    parameter int WIDTH_B = 4,
    parameter logic signed [WIDTH_B-1:0] B_INIT [N+1] = '{4'sd1, 4'sd2, 4'sd3, 4'sd4},
    parameter int WIDTH_Y = calc_width_y(WIDTH_X, WIDTH_B, N),
    localparam int CHW    = (CH > 1) ? $clog2(CH) : 1,
    localparam int AW     = (N > 0) ? $clog2(N + 1) : 1
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic signed [WIDTH_X-1:0] s_data,
    input  logic [CHW-1:0]            s_ch,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic signed [WIDTH_Y-1:0] m_data,
    output logic [CHW-1:0]            m_ch,
    input  logic                      coef_we,
    input  logic [AW-1:0]             coef_addr,
    input  logic signed [WIDTH_B-1:0] coef_data
);

    localparam logic [AW-1:0] LAST_TAP = AW'(N);

    logic [1:0]                state;
    logic [AW-1:0]             tap;
    logic [CHW-1:0]            ch_q;
    logic signed [WIDTH_X-1:0] hist [CH][N+1];
    logic signed [WIDTH_B-1:0] coef [N+1];
    logic signed [WIDTH_Y-1:0] mac_sum;
    logic                      accept;
    logic                      ch_ok;
    logic                      start;
    logic                      last_tap;
    logic                      mac_en;

    assign s_ready  = (state == IDLE) && !rst;
    assign accept   = s_valid && s_ready;
    assign ch_ok    = int'(s_ch) < CH;
    // Out-of-range channels and samples colliding with clear complete the handshake but start nothing
    assign start    = accept && ch_ok && !clear;
    assign last_tap = (tap == LAST_TAP);
    assign mac_en   = (state == MAC) && !clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tap     <= '0;
            ch_q    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= '0;
        end else if (clear) begin
            state   <= IDLE;
            tap     <= '0;
            m_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= MAC;
                        tap   <= '0;
                        ch_q  <= s_ch;
                    end
                end
                MAC: begin
                    if (last_tap) begin
                        state   <= OUT;
                        tap     <= '0;
                        m_valid <= 1'b1;
                        m_data  <= mac_sum;
                        m_ch    <= ch_q;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Coefficient writes only land while idle, so a computation never sees a half-updated set
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                for (int i = 0; i <= N; i++) begin
                    hist[c][i] <= '0;
                end
            end
            for (int i = 0; i <= N; i++) begin
                coef[i] <= B_INIT[i];
            end
        end else begin
            if (clear) begin
                for (int c = 0; c < CH; c++) begin
                    for (int i = 0; i <= N; i++) begin
                        hist[c][i] <= '0;
                    end
                end
            end else if (start) begin
                for (int i = N; i > 0; i--) begin
                    hist[s_ch][i] <= hist[s_ch][i-1];
                end
                hist[s_ch][0] <= s_data;
            end
            if (coef_we && (state == IDLE) && (int'(coef_addr) <= N)) begin
                coef[coef_addr] <= coef_data;
            end
        end
    end

    fir_mac #(
        .WIDTH_X (WIDTH_X),
        .WIDTH_B (WIDTH_B),
        .WIDTH_Y (WIDTH_Y)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (mac_en),
        .x   (hist[ch_q][tap]),
        .b   (coef[tap]),
        .sum (mac_sum)
    );

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Directed, table-driven bench for fir_filter_tdm with three channels so that
// an out-of-range channel id is representable on s_ch.
module tb_fir_filter_tdm;

    localparam int N   = 3;
    localparam int CH  = 3;
    localparam int WX  = 4;
    localparam int WB  = 4;
    localparam int WY  = 10;
    localparam int LAT = N + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clear;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [WX-1:0] s_data;
    logic [1:0]           s_ch;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [WY-1:0] m_data;
    logic [1:0]           m_ch;
    logic                 coef_we;
    logic [1:0]           coef_addr;
    logic signed [WB-1:0] coef_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int ch;
        int data;
        int exp_data;
        int exp_ch;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    fir_filter_tdm #(
        .N       (N),
        .CH      (CH),
        .WIDTH_X (WX),
        .WIDTH_B (WB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_ch      (s_ch),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_ch      (m_ch),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("s_ready_wait", int'(s_ready), 1);
    endtask

    // Presents one sample and returns at the negedge right after the accepting edge
    task automatic applyStimulus(input int ch, input int data);
        waitReady();
        s_valid = 1'b1;
        s_ch    = 2'(ch);
        s_data  = 4'(data);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runSample(input int ch, input int data, input int exp_data, input int exp_ch);
        int lat;
        applyStimulus(ch, data);
        waitResult(lat);
        checkOutput("latency", lat, LAT);
        checkOutput("m_data", int'(m_data), exp_data);
        checkOutput("m_ch", int'(m_ch), exp_ch);
    endtask

    task automatic writeCoef(input int addr, input int data);
        waitReady();
        coef_we   = 1'b1;
        coef_addr = 2'(addr);
        coef_data = 4'(data);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic pulseClear();
        waitReady();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic watchNoOutput(input string name, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        checkOutput(name, seen, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;

        // Impulse on ch0, then ch1 zero, interleave, then extremes with all b=-8
        vecs[0]  = '{0,  1,   1, 0};
        vecs[1]  = '{0,  0,   2, 0};
        vecs[2]  = '{0,  0,   3, 0};
        vecs[3]  = '{0,  0,   4, 0};
        vecs[4]  = '{0,  0,   0, 0};
        vecs[5]  = '{1,  0,   0, 1};
        vecs[6]  = '{0,  3,   3, 0};
        vecs[7]  = '{1, -2,  -2, 1};
        vecs[8]  = '{0,  1,   7, 0};
        vecs[9]  = '{0, -8,  32, 0};
        vecs[10] = '{0, -8,  96, 0};
        vecs[11] = '{0, -8, 184, 0};
        vecs[12] = '{0, -8, 256, 0};

        rst       = 1'b1;
        clear     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_ch      = '0;
        m_ready   = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_m_valid", int'(m_valid), 0);
        checkOutput("rst_m_data", int'(m_data), 0);
        checkOutput("rst_m_ch", int'(m_ch), 0);
        checkOutput("rst_s_ready", int'(s_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_s_ready", int'(s_ready), 1);

        for (int i = 0; i < 13; i++) begin
            if (i == 9) begin
                for (int a = 0; a <= N; a++) writeCoef(a, -8);
            end
            runSample(vecs[i].ch, vecs[i].data, vecs[i].exp_data, vecs[i].exp_ch);
        end

        for (int a = 0; a <= N; a++) writeCoef(a, a + 1);

        // Backpressure: ch1 history becomes {3,-2,0,0} -> 3 - 4 = -1
        m_ready = 1'b0;
        runSample(1, 3, -1, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_m_valid", int'(m_valid), 1);
            checkOutput("bp_m_data", int'(m_data), -1);
            checkOutput("bp_m_ch", int'(m_ch), 1);
            checkOutput("bp_s_ready", int'(s_ready), 0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_s_ready", int'(s_ready), 1);
        checkOutput("bp_release_m_valid", int'(m_valid), 0);

        // A coefficient write during MAC is dropped
        pulseClear();
        applyStimulus(0, 1);
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 4'sd5;
        @(negedge clk);
        coef_we = 1'b0;
        waitResult(lat);
        checkOutput("mac_write_dropped", int'(m_data), 1);

        // The same write while idle takes effect
        pulseClear();
        writeCoef(0, 5);
        runSample(0, 1, 5, 0);
        writeCoef(0, 1);

        // Clear during MAC aborts and wipes every history
        applyStimulus(0, 7);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        watchNoOutput("clear_abort_no_output", 8);
        runSample(0, 5, 5, 0);
        runSample(1, 0, 0, 1);

        // Clear together with an accept discards the sample
        waitReady();
        s_valid = 1'b1;
        s_ch    = 2'd0;
        s_data  = 4'sd7;
        clear   = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        clear   = 1'b0;
        checkOutput("clear_accept_s_ready", int'(s_ready), 1);
        watchNoOutput("clear_accept_no_output", 6);
        runSample(0, 0, 0, 0);

        // Channel id equal to CH is accepted but produces nothing
        applyStimulus(CH, 6);
        watchNoOutput("bad_ch_no_output", 8);
        checkOutput("bad_ch_s_ready", int'(s_ready), 1);
        runSample(0, 2, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
